ddr_phase_step_ctrl: RTL and testbench

//  Sequencer directly upstream of gowin_ddr_clocking. Converts a requested absolute read-clock

---
 rtl/ddr_clk_pkg.sv | 40 ++++
 rtl/ddr_phase_step_ctrl_if.sv | 30 +++
 rtl/ddr_sync2.sv | 24 ++
 rtl/ddr_phase_step_ctrl.sv | 134 +++++++++++++
 tb/tb_ddr_phase_step_ctrl.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ddr_clk_pkg.sv
// Shared types for the DDR read-clock phase sequencer and gowin_ddr_clocking users.
// Phase indices wrap modulo PHASE_STEPS; rotation helpers live here so callers agree on them.
package ddr_clk_pkg;

    localparam int PHASE_STEPS = 16;
    localparam int PHASE_W     = $clog2(PHASE_STEPS);
    localparam int HALF_STEPS  = PHASE_STEPS / 2;

    typedef logic [PHASE_W-1:0] phase_t;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STEP,
        GAP,
        WAIT_LOCK,
        DONE
    } ps_state_t;

    typedef struct packed {
        logic   updn;
        phase_t count;
    } rot_t;

    // Shortest rotation from cur to tgt; a half-turn tie goes forward.
    function automatic rot_t shortest_rot(input phase_t tgt, input phase_t cur);
        phase_t diff;
        rot_t   r;
        diff = tgt - cur;
        if (diff <= phase_t'(HALF_STEPS)) begin
            r.updn  = 1'b1;
            r.count = diff;
        end else begin
            r.updn  = 1'b0;
            r.count = phase_t'(0) - diff;
        end
        return r;
    endfunction

endpackage

// File: rtl/ddr_phase_step_ctrl_if.sv
// Request/status bundle between calibration logic (master) and the phase-step sequencer (slave).
// Handshake: a request transfers on a clock edge where target_valid and target_ready are both high.
interface ddr_phase_step_ctrl_if;
    import ddr_clk_pkg::*;

    phase_t    target_phase;
    logic      target_valid;
    logic      target_ready;
    logic      pll_locked;
    logic      phase_step;
    logic      phase_updn;
    phase_t    cur_phase;
    logic      busy;
    logic      done;
    logic      timeout_err;
    ps_state_t dbg_state;

    modport master (
        output target_phase, target_valid, pll_locked,
        input  target_ready, phase_step, phase_updn, cur_phase,
               busy, done, timeout_err, dbg_state
    );

    modport slave (
        input  target_phase, target_valid, pll_locked,
        output target_ready, phase_step, phase_updn, cur_phase,
               busy, done, timeout_err, dbg_state
    );

endinterface

// File: rtl/ddr_sync2.sv
// Two-flop synchroniser with asynchronous reset for a slow level signal (PLL lock).
module ddr_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/ddr_phase_step_ctrl.sv
// Turns an absolute read-clock phase request into spaced PLL phase_step pulses along the
// shortest rotation, then waits for re-lock and reports the phase now applied.
module ddr_phase_step_ctrl
    import ddr_clk_pkg::*;
#(
    parameter int RESET_PHASE  = 4,
    parameter int STEP_GAP     = 8,
    parameter int LOCK_TIMEOUT = 4096
) (
    input logic                  clk,
    input logic                  rst,
    ddr_phase_step_ctrl_if.slave bus
);

    localparam int CNT_MAX = (LOCK_TIMEOUT > STEP_GAP) ? LOCK_TIMEOUT : STEP_GAP;
    localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    localparam phase_t           RESET_PH  = phase_t'(RESET_PHASE);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STEP_GAP - 2);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);

    ps_state_t        r_state;
    phase_t           r_cur;
    phase_t           r_rem;
    logic             r_updn;
    logic             r_step;
    logic             r_busy;
    logic             r_done;
    logic             r_terr;
    logic [CNT_W-1:0] r_cnt;

    logic w_locked;
    logic w_ready;
    rot_t w_rot;

    ddr_sync2 u_lock_sync (
        .clk (clk),
        .rst (rst),
        .i_d (bus.pll_locked),
        .o_q (w_locked)
    );

    assign w_ready = (r_state == IDLE) && w_locked;
    assign w_rot   = shortest_rot(bus.target_phase, r_cur);

    // r_cur moves on the same edge that raises phase_step, so it always reflects
    // the phase the PLL has been told to apply.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cur   <= RESET_PH;
            r_rem   <= '0;
            r_updn  <= 1'b0;
            r_step  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_terr  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_step <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.target_valid && w_ready) begin
                        r_busy <= 1'b1;
                        r_terr <= 1'b0;
                        if (w_rot.count == '0) begin
                            r_state <= DONE;
                        end else begin
                            r_updn  <= w_rot.updn;
                            r_rem   <= w_rot.count;
                            r_state <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    r_step  <= 1'b1;
                    r_cur   <= r_updn ? r_cur + phase_t'(1) : r_cur - phase_t'(1);
                    r_rem   <= r_rem - phase_t'(1);
                    r_state <= STEP;
                end
                STEP: begin
                    r_cnt   <= '0;
                    r_state <= GAP;
                end
                GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        r_cnt <= '0;
                        if (r_rem != '0) begin
                            r_step  <= 1'b1;
                            r_cur   <= r_updn ? r_cur + phase_t'(1) : r_cur - phase_t'(1);
                            r_rem   <= r_rem - phase_t'(1);
                            r_state <= STEP;
                        end else begin
                            r_state <= WAIT_LOCK;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (w_locked) begin
                        r_state <= DONE;
                    end else if (r_cnt == LOCK_LAST) begin
                        r_terr  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.target_ready = w_ready;
    assign bus.phase_step   = r_step;
    assign bus.phase_updn   = r_updn;
    assign bus.cur_phase    = r_cur;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.timeout_err  = r_terr;
    assign bus.dbg_state    = r_state;

endmodule

// File: tb/tb_ddr_phase_step_ctrl.sv
// Randomised bench for ddr_phase_step_ctrl against a shortest-rotation phase model.
module tb_ddr_phase_step_ctrl;
    import ddr_clk_pkg::*;

    localparam int NSTEP        = 16;
    localparam int RESET_PHASE  = 4;
    localparam int STEP_GAP     = 8;
    localparam int LOCK_TIMEOUT = 4096;

    logic clk = 1'b0;
    logic rst;

    ddr_phase_step_ctrl_if bus_if ();

    ddr_phase_step_ctrl #(
        .RESET_PHASE  (RESET_PHASE),
        .STEP_GAP     (STEP_GAP),
        .LOCK_TIMEOUT (LOCK_TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int acc_cnt = 0;
    int done_cnt  = 0;
    int pulse_idx = 0;
    int acc_cyc   = 0;
    int req_done0 = 0;
    int exp_dir   = 0;
    int exp_n     = 0;
    int m_phase   = RESET_PHASE;
    logic prev_updn = 1'b0;
    logic [3:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus_if.target_valid && bus_if.target_ready) acc_cnt++;
    end

    // Pulse monitor: timing, direction, direction stability and applied phase of every pulse.
    always @(negedge clk) begin
        if (bus_if.done) done_cnt++;
        if (bus_if.phase_step) begin
            if (exp_q.size() == 0) begin
                check("pulse_unexpected", 32'd1, 32'd0);
            end else begin
                check("pulse_cyc", cyc, acc_cyc + 1 + STEP_GAP * pulse_idx);
                check("pulse_dir", bus_if.phase_updn, exp_dir);
                check("updn_stable", bus_if.phase_updn, prev_updn);
                check("pulse_phase", bus_if.cur_phase, exp_q.pop_front());
            end
            pulse_idx++;
        end
        prev_updn = bus_if.phase_updn;
    end

    function automatic void plan(input int tgt);
        int diff;
        diff = (tgt - m_phase + NSTEP) % NSTEP;
        if (diff == 0) begin
            exp_n = 0;
        end else if (diff <= NSTEP / 2) begin
            exp_dir = 1;
            exp_n   = diff;
        end else begin
            exp_dir = 0;
            exp_n   = NSTEP - diff;
        end
        exp_q.delete();
        for (int k = 1; k <= exp_n; k++)
            exp_q.push_back(4'((m_phase + (exp_dir == 1 ? k : NSTEP - k)) % NSTEP));
        m_phase = tgt;
    endfunction

    // Call at a falling edge.
    task automatic start_req(input int tgt, input bit hold);
        int w;
        w = 0;
        while (!bus_if.target_ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        check("ready_wait", bus_if.target_ready, 1);
        plan(tgt);
        pulse_idx = 0;
        req_done0 = done_cnt;
        bus_if.target_phase = 4'(tgt);
        bus_if.target_valid = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        if (!hold) bus_if.target_valid = 1'b0;
        check("busy_after_accept", bus_if.busy, 1);
        check("terr_cleared", bus_if.timeout_err, 0);
    endtask

    task automatic wait_done(input bit hold);
        int w;
        bit seen;
        w = 0;
        seen = 1'b0;
        while (!seen && w < 200) begin
            @(negedge clk);
            w++;
            if (bus_if.done) seen = 1'b1;
        end
        if (hold) bus_if.target_valid = 1'b0;
        check("done_seen", seen, 1);
        if (seen) begin
            check("done_cyc", cyc, acc_cyc + (exp_n == 0 ? 1 : STEP_GAP * exp_n + 3));
            check("done_phase", bus_if.cur_phase, m_phase);
            check("done_busy", bus_if.busy, 0);
            check("done_pulses", pulse_idx, exp_n);
            check("done_terr", bus_if.timeout_err, 0);
        end
        @(negedge clk);
        check("done_one_clk", bus_if.done, 0);
        check("done_count", done_cnt - req_done0, 1);
        check("q_empty", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int w;
        int a0;
        int d0;
        int tgt;
        bit seen;

        rst = 1'b1;
        bus_if.pll_locked   = 1'b0;
        bus_if.target_valid = 1'b0;
        bus_if.target_phase = '0;
        repeat (3) @(negedge clk);
        check("rst_cur", bus_if.cur_phase, RESET_PHASE);
        check("rst_busy", bus_if.busy, 0);
        check("rst_step", bus_if.phase_step, 0);
        check("rst_updn", bus_if.phase_updn, 0);
        check("rst_done", bus_if.done, 0);
        check("rst_terr", bus_if.timeout_err, 0);
        check("rst_ready", bus_if.target_ready, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("ready_nolock", bus_if.target_ready, 0);
        bus_if.pll_locked = 1'b1;

        start_req(7, 0);  wait_done(0);
        start_req(1, 0);  wait_done(0);
        start_req(14, 0); wait_done(0);
        start_req(0, 0);  wait_done(0);
        start_req(8, 0);  wait_done(0);
        start_req(4, 0);  wait_done(0);
        start_req(4, 0);  wait_done(0);

        a0 = acc_cnt;
        start_req(9, 1);
        wait_done(1);
        check("one_accept", acc_cnt - a0, 1);

        for (int i = 0; i < 24; i++) begin
            tgt = int'($urandom_range(0, NSTEP - 1));
            a0  = acc_cnt;
            if ($urandom_range(0, 1) == 1) begin
                start_req(tgt, 1); wait_done(1);
            end else begin
                start_req(tgt, 0); wait_done(0);
            end
            check("rand_accept", acc_cnt - a0, 1);
        end

        // Lock lost for the whole request: pulses still go out, then the lock wait expires.
        start_req((m_phase + 3) % NSTEP, 0);
        bus_if.pll_locked = 1'b0;
        d0 = done_cnt;
        w = 0;
        seen = 1'b0;
        while (!seen && w < LOCK_TIMEOUT + 200) begin
            @(negedge clk);
            w++;
            if (bus_if.timeout_err) seen = 1'b1;
        end
        check("terr_seen", seen, 1);
        check("terr_cyc", cyc, acc_cyc + STEP_GAP * exp_n + 1 + LOCK_TIMEOUT);
        check("terr_no_done", done_cnt - d0, 0);
        check("terr_busy", bus_if.busy, 0);
        check("terr_phase", bus_if.cur_phase, m_phase);
        check("terr_pulses", pulse_idx, exp_n);
        check("terr_ready", bus_if.target_ready, 0);
        bus_if.pll_locked = 1'b1;
        repeat (5) @(negedge clk);
        check("terr_sticky", bus_if.timeout_err, 1);
        start_req((m_phase + 13) % NSTEP, 0);
        wait_done(0);

        // Reset in the gap after the second pulse.
        start_req((m_phase + 5) % NSTEP, 0);
        w = 0;
        while (pulse_idx < 2 && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("rst_test_pulses", pulse_idx, 2);
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_step", bus_if.phase_step, 0);
        check("midrst_busy", bus_if.busy, 0);
        check("midrst_done", bus_if.done, 0);
        check("midrst_cur", bus_if.cur_phase, RESET_PHASE);
        check("midrst_ready", bus_if.target_ready, 0);
        check("midrst_updn", bus_if.phase_updn, 0);
        exp_q.delete();
        m_phase = RESET_PHASE;
        @(negedge clk);
        rst = 1'b0;
        w = 0;
        while (!bus_if.target_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("ready_after_rst", bus_if.target_ready, 1);
        check("ready_rst_lat", w, 2);
        start_req(12, 0);
        wait_done(0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
